// File: rtl/ps2_zx_keyboard.sv
// PS/2 set-2 keyboard front end for the Spectrum core.
// Deserialises PS/2 frames, tracks E0/F0 prefixes, maintains the 8x5 ZX key
// matrix (base + composite register sets) plus F1..F11 and Alt/Ctrl/L-GUI.
// Optional feature macro: ZXKBD_CURSOR_EN (E0 arrow keys -> CS+5/6/7/8).
`timescale 1ns/1ps
module ps2_zx_keyboard #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_kbd_clk,
  input  logic        ps2_kbd_data,
  input  logic [15:0] addr,
  output logic [4:0]  key_data,
  output logic [11:1] Fn,
  output logic [2:0]  mod
);
  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [FCW-1:0] FLT_MAX = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TO_MAX  = TCW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} rx_st_t;

  logic [1:0]     clk_sync_q, dat_sync_q;
  logic           clk_filt_q, dat_filt_q, clk_prev_q;
  logic [FCW-1:0] clk_cnt_q, dat_cnt_q;
  rx_st_t         rx_st_q;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     shift_q, byte_q;
  logic           par_q, byte_stb_q;
  logic [TCW-1:0] to_cnt_q;
  logic           ext_q, rel_q;
  logic [39:0]    matrix_q, matrix_d, comp_q, comp_d, base_m, comp_m, eff;
  logic [11:1]    fn_q, fn_d, fn_m;
  logic [2:0]     mod_q, mod_d, mod_m;
  logic           fall;

  // Two-flop synchronisers for the asynchronous PS/2 lines (idle high)
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_kbd_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_kbd_data};
    end
  end

  // Stability filters: a new level is accepted only after FILTER_LEN steady cycles
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_filt_q <= 1'b1; dat_filt_q <= 1'b1; clk_prev_q <= 1'b1;
      clk_cnt_q  <= '0;   dat_cnt_q  <= '0;
    end else begin
      clk_prev_q <= clk_filt_q;
      if (clk_sync_q[1] == clk_filt_q) clk_cnt_q <= '0;
      else if (clk_cnt_q == FLT_MAX) begin clk_filt_q <= clk_sync_q[1]; clk_cnt_q <= '0; end
      else clk_cnt_q <= clk_cnt_q + 1'b1;
      if (dat_sync_q[1] == dat_filt_q) dat_cnt_q <= '0;
      else if (dat_cnt_q == FLT_MAX) begin dat_filt_q <= dat_sync_q[1]; dat_cnt_q <= '0; end
      else dat_cnt_q <= dat_cnt_q + 1'b1;
    end
  end

  assign fall = clk_prev_q & ~clk_filt_q;

  // Frame receiver: start, 8 data LSB first, odd parity, stop; aborts on timeout
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rx_st_q <= S_IDLE; bit_cnt_q <= '0; shift_q <= '0; par_q <= 1'b0;
      to_cnt_q <= '0; byte_stb_q <= 1'b0; byte_q <= '0;
    end else begin
      byte_stb_q <= 1'b0;
      if (fall || rx_st_q == S_IDLE) to_cnt_q <= '0;
      else                           to_cnt_q <= to_cnt_q + 1'b1;
      if (fall) begin
        case (rx_st_q)
          S_IDLE: if (!dat_filt_q) begin rx_st_q <= S_DATA; bit_cnt_q <= '0; end
          S_DATA: begin
            shift_q   <= {dat_filt_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) rx_st_q <= S_PAR;
          end
          S_PAR: begin par_q <= dat_filt_q; rx_st_q <= S_STOP; end
          default: begin
            if (dat_filt_q && (^{shift_q, par_q})) begin
              byte_stb_q <= 1'b1;
              byte_q     <= shift_q;
            end
            rx_st_q <= S_IDLE;
          end
        endcase
      end else if (rx_st_q != S_IDLE && to_cnt_q == TO_MAX) begin
        rx_st_q <= S_IDLE;
      end
    end
  end

  // Scan-code decode into one-hot masks (matrix index = row*5 + bit)
  always_comb begin
    base_m = '0; comp_m = '0; fn_m = '0; mod_m = '0;
    if (!ext_q) begin
      case (byte_q)
        8'h12: base_m[0]  = 1'b1; 8'h1A: base_m[1]  = 1'b1; 8'h22: base_m[2]  = 1'b1;
        8'h21: base_m[3]  = 1'b1; 8'h2A: base_m[4]  = 1'b1;
        8'h1C: base_m[5]  = 1'b1; 8'h1B: base_m[6]  = 1'b1; 8'h23: base_m[7]  = 1'b1;
        8'h2B: base_m[8]  = 1'b1; 8'h34: base_m[9]  = 1'b1;
        8'h15: base_m[10] = 1'b1; 8'h1D: base_m[11] = 1'b1; 8'h24: base_m[12] = 1'b1;
        8'h2D: base_m[13] = 1'b1; 8'h2C: base_m[14] = 1'b1;
        8'h16: base_m[15] = 1'b1; 8'h1E: base_m[16] = 1'b1; 8'h26: base_m[17] = 1'b1;
        8'h25: base_m[18] = 1'b1; 8'h2E: base_m[19] = 1'b1;
        8'h45: base_m[20] = 1'b1; 8'h46: base_m[21] = 1'b1; 8'h3E: base_m[22] = 1'b1;
        8'h3D: base_m[23] = 1'b1; 8'h36: base_m[24] = 1'b1;
        8'h4D: base_m[25] = 1'b1; 8'h44: base_m[26] = 1'b1; 8'h43: base_m[27] = 1'b1;
        8'h3C: base_m[28] = 1'b1; 8'h35: base_m[29] = 1'b1;
        8'h5A: base_m[30] = 1'b1; 8'h4B: base_m[31] = 1'b1; 8'h42: base_m[32] = 1'b1;
        8'h3B: base_m[33] = 1'b1; 8'h33: base_m[34] = 1'b1;
        8'h29: base_m[35] = 1'b1; 8'h59: base_m[36] = 1'b1; 8'h3A: base_m[37] = 1'b1;
        8'h31: base_m[38] = 1'b1; 8'h32: base_m[39] = 1'b1;
        8'h66: begin comp_m[0]  = 1'b1; comp_m[20] = 1'b1; end
        8'h76: begin comp_m[0]  = 1'b1; comp_m[35] = 1'b1; end
        8'h41: begin comp_m[36] = 1'b1; comp_m[38] = 1'b1; end
        8'h49: begin comp_m[36] = 1'b1; comp_m[37] = 1'b1; end
        8'h05: fn_m[1]  = 1'b1; 8'h06: fn_m[2]  = 1'b1; 8'h04: fn_m[3]  = 1'b1;
        8'h0C: fn_m[4]  = 1'b1; 8'h03: fn_m[5]  = 1'b1; 8'h0B: fn_m[6]  = 1'b1;
        8'h83: fn_m[7]  = 1'b1; 8'h0A: fn_m[8]  = 1'b1; 8'h01: fn_m[9]  = 1'b1;
        8'h09: fn_m[10] = 1'b1; 8'h78: fn_m[11] = 1'b1;
        default: ;
      endcase
    end else begin
      case (byte_q)
        8'h1F: mod_m[2] = 1'b1;
`ifdef ZXKBD_CURSOR_EN
        8'h6B: begin comp_m[0] = 1'b1; comp_m[19] = 1'b1; end
        8'h72: begin comp_m[0] = 1'b1; comp_m[24] = 1'b1; end
        8'h75: begin comp_m[0] = 1'b1; comp_m[23] = 1'b1; end
        8'h74: begin comp_m[0] = 1'b1; comp_m[22] = 1'b1; end
`else
`endif
        default: ;
      endcase
    end
    // Alt and Ctrl act the same with or without the E0 prefix
    if (byte_q == 8'h11) mod_m[0] = 1'b1;
    if (byte_q == 8'h14) mod_m[1] = 1'b1;
  end

  // Apply press (set) or release (clear); typematic repeats are idempotent
  always_comb begin
    matrix_d = rel_q ? (matrix_q & ~base_m) : (matrix_q | base_m);
    comp_d   = rel_q ? (comp_q   & ~comp_m) : (comp_q   | comp_m);
    fn_d     = rel_q ? (fn_q     & ~fn_m)   : (fn_q     | fn_m);
    mod_d    = rel_q ? (mod_q    & ~mod_m)  : (mod_q    | mod_m);
  end

  // Decoder state: prefix flags, then key update one cycle after the byte strobe
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ext_q <= 1'b0; rel_q <= 1'b0;
      matrix_q <= '0; comp_q <= '0; fn_q <= '0; mod_q <= '0;
    end else if (byte_stb_q) begin
      if (byte_q == 8'hE0)      ext_q <= 1'b1;
      else if (byte_q == 8'hF0) rel_q <= 1'b1;
      else begin
        ext_q <= 1'b0; rel_q <= 1'b0;
        matrix_q <= matrix_d; comp_q <= comp_d; fn_q <= fn_d; mod_q <= mod_d;
      end
    end
  end

  // ULA read: OR of selected half-rows, active low, combinational from the registers
  always_comb begin
    eff = matrix_q | comp_q;
    key_data = 5'h1F;
    for (int b = 0; b < 5; b++) begin
      for (int r = 0; r < 8; r++) begin
        if (eff[r*5+b] && !addr[8+r]) key_data[b] = 1'b0;
      end
    end
  end

  assign Fn  = fn_q;
  assign mod = mod_q;
endmodule

// File: tb/tb_ps2_zx_keyboard.sv
// Directed bench for ps2_zx_keyboard: PS/2 frames driven bit by bit, key_data,
// Fn and mod checked with immediate assertions against hand-computed values.
`timescale 1ns/1ps
module tb_ps2_zx_keyboard;
  localparam int TO_CYC = 4096;
  localparam int H      = 20;

  logic        clk_sys = 1'b0, reset = 1'b1;
  logic        kc = 1'b1, kd = 1'b1;
  logic [15:0] addr = 16'hFFFF;
  logic [4:0]  key_data;
  logic [11:1] Fn;
  logic [2:0]  mod;
  int n_chk = 0, n_fail = 0;

  ps2_zx_keyboard #(.FILTER_LEN(8), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_kbd_clk(kc), .ps2_kbd_data(kd),
    .addr(addr), .key_data(key_data), .Fn(Fn), .mod(mod));

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [4:0] exp);
    @(negedge clk_sys);
    addr = a;
    #1;
    chk(tag, {11'b0, key_data}, {11'b0, exp});
  endtask

  task automatic bit_out(input logic v);
    kd = v;
    repeat (H) @(posedge clk_sys);
    kc = 1'b0;
    repeat (H) @(posedge clk_sys);
    kc = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic bad);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < 11; i++) bit_out(fr[i]);
    kd = 1'b1;
    repeat (40) @(posedge clk_sys);
  endtask

  initial begin
    repeat (5) @(posedge clk_sys);
    reset = 1'b0;
    // reset state
    rd("rst_all_rows", 16'h00FE, 5'h1F);
    chk("rst_fn", {5'b0, Fn}, 16'h0000);
    chk("rst_mod", {13'b0, mod}, 16'h0000);

    // 1: make A
    send(8'h1C, 1'b0);
    rd("a_row1", 16'hFDFE, 5'h1E);
    rd("a_row0", 16'hFEFE, 5'h1F);
    // typematic repeat then a single release
    send(8'h1C, 1'b0);
    rd("a_repeat", 16'hFDFE, 5'h1E);

    // 2: break A, then a bad-parity A frame must be dropped
    send(8'hF0, 1'b0); send(8'h1C, 1'b0);
    rd("a_break", 16'hFDFE, 5'h1F);
    send(8'h1C, 1'b1);
    rd("bad_parity", 16'hFDFE, 5'h1F);
    send(8'h1B, 1'b0);
    rd("s_after_bad", 16'hFDFE, 5'h1D);
    send(8'hF0, 1'b0); send(8'h1B, 1'b0);
    rd("s_break", 16'hFDFE, 5'h1F);

    // release of a never-pressed key
    send(8'hF0, 1'b0); send(8'h1A, 1'b0);
    rd("stray_break", 16'h00FE, 5'h1F);

    // two half-rows selected at once: Z (r0b1) and G (r1b4)
    send(8'h1A, 1'b0); send(8'h34, 1'b0);
    rd("multi_row", 16'hFCFE, 5'h0D);
    rd("row0_only", 16'hFEFE, 5'h1D);
    send(8'hF0, 1'b0); send(8'h1A, 1'b0);
    send(8'hF0, 1'b0); send(8'h34, 1'b0);
    rd("multi_clear", 16'hFCFE, 5'h1F);

    // 3: held CS survives a Backspace composite release
    send(8'h12, 1'b0);
    rd("cs_held", 16'hFEFE, 5'h1E);
    send(8'h66, 1'b0);
    rd("bksp_zero", 16'hEFFE, 5'h1E);
    send(8'hF0, 1'b0); send(8'h66, 1'b0);
    rd("bksp_rel_cs", 16'hFEFE, 5'h1E);
    rd("bksp_rel_zero", 16'hEFFE, 5'h1F);
    send(8'hF0, 1'b0); send(8'h12, 1'b0);
    rd("cs_rel", 16'hFEFE, 5'h1F);

    // comma composite: SS (r7b1) + N (r7b3)
    send(8'h41, 1'b0);
    rd("comma", 16'h7FFE, 5'h15);
    send(8'hF0, 1'b0); send(8'h41, 1'b0);
    rd("comma_rel", 16'h7FFE, 5'h1F);

    // 4: Ctrl + F11, then Alt via E0 11
    send(8'h14, 1'b0); send(8'h78, 1'b0);
    chk("ctrl_mod", {13'b0, mod}, 16'h0002);
    chk("f11_set", {5'b0, Fn}, 16'h0400);
    send(8'hF0, 1'b0); send(8'h78, 1'b0);
    chk("f11_rel", {5'b0, Fn}, 16'h0000);
    send(8'hE0, 1'b0); send(8'h11, 1'b0);
    chk("ralt_mod", {13'b0, mod}, 16'h0003);
    send(8'hE0, 1'b0); send(8'h1F, 1'b0);
    chk("lgui_mod", {13'b0, mod}, 16'h0007);
    send(8'h05, 1'b0);
    chk("f1_set", {5'b0, Fn}, 16'h0001);

    // 5: frame stalls after 4 data bits, receiver must time out
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'b1);
    kd = 1'b1;
    repeat (TO_CYC + 200) @(posedge clk_sys);
    send(8'h29, 1'b0);
    rd("timeout_spc", 16'h7FFE, 5'h1E);
    rd("timeout_row0", 16'hFEFE, 5'h1F);

    // 6: E0 75 (cursor up)
    send(8'hE0, 1'b0); send(8'h75, 1'b0);
`ifdef ZXKBD_CURSOR_EN
    rd("cur_up_7", 16'hEFFE, 5'h17);
    rd("cur_up_cs", 16'hFEFE, 5'h1E);
`else
    rd("cur_up_7", 16'hEFFE, 5'h1F);
    rd("cur_up_cs", 16'hFEFE, 5'h1F);
`endif
    // prefix consumed: a following plain code decodes normally
    send(8'h1C, 1'b0);
    rd("after_e0", 16'hFDFE, 5'h1E);

    // reset clears everything
    @(negedge clk_sys); reset = 1'b1;
    repeat (2) @(posedge clk_sys);
    reset = 1'b0;
    rd("rst2_rows", 16'h00FE, 5'h1F);
    chk("rst2_mod", {13'b0, mod}, 16'h0000);
    chk("rst2_fn", {5'b0, Fn}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
